// File: rtl/piso_shift_tx_pkg.sv
// rtl/piso_shift_tx_pkg.sv - shared FSM encodings and default idle level for the PISO transmitter
package piso_shift_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/piso_shift_tx_bit_counter.sv
// rtl/piso_shift_tx_bit_counter.sv - mod-WIDTH bit counter with terminal-count flag
module bit_counter #(
  parameter int WIDTH = 4,
  localparam int CW   = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // clr wins over en so a reload on the final bit restarts at zero
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == LAST);

endmodule

// File: rtl/piso_shift_tx.sv
// rtl/piso_shift_tx.sv - parallel-in/serial-out transmitter, LSB first, gapless back-to-back words
module piso_shift_tx
  import piso_shift_tx_pkg::*;
#(
  parameter int   WIDTH    = 4,
  parameter logic IDLE_BIT = IDLE_BIT_DEFAULT,
  localparam int  CW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] p_in,
  input  logic             p_valid,
  output logic             p_ready,
  output logic             s_out,
  output logic             s_active,
  output logic             s_last
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             accept;
  logic             shifting;

  assign shifting = (state_q == ST_SHIFT);
  assign accept   = p_valid & p_ready;

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (shifting & en),
    .count (cnt),
    .tc    (tc)
  );

  // Ready depends only on registered state and en, never on p_valid
  assign p_ready = ~shifting | (en & tc);

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          sreg_d  = p_in;
        end
      end
      ST_SHIFT: begin
        if (en) begin
          if (tc) begin
            if (accept) begin
              sreg_d = p_in;
            end else begin
              state_d = ST_IDLE;
              sreg_d  = '0;
            end
          end else begin
            sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        sreg_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
    end
  end

  assign s_out    = shifting ? sreg_q[0] : IDLE_BIT;
  assign s_active = shifting;
  assign s_last   = shifting & (cnt == LAST);

endmodule

// File: tb/tb_piso_shift_tx.sv
// tb/tb_piso_shift_tx.sv - scoreboard bench for piso_shift_tx with a chained negedge SIPO model
module tb_piso_shift_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] p_in;
  logic       p_valid;
  logic       p_ready;
  logic       s_out;
  logic       s_active;
  logic       s_last;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       b;
    logic       last;
    logic [3:0] word;
  } exp_bit_t;

  exp_bit_t   sbq[$];
  logic [3:0] sipo = 4'b0000;

  piso_shift_tx #(
    .WIDTH    (4),
    .IDLE_BIT (1'b0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .p_in     (p_in),
    .p_valid  (p_valid),
    .p_ready  (p_ready),
    .s_out    (s_out),
    .s_active (s_active),
    .s_last   (s_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor + reference model: runs on negedge, away from the DUT's active edge
  always @(negedge clk) begin
    logic     busy;
    logic     exp_ready;
    exp_bit_t e;
    if (!rst_n) begin
      sbq.delete();
    end else begin
      busy      = (sbq.size() != 0);
      exp_ready = 1'b1;
      if (busy) exp_ready = en && sbq[0].last;
      chk("p_ready", p_ready, exp_ready);
      chk("s_active", s_active, busy);
      if (busy) begin
        chk("s_out", s_out, sbq[0].b);
        chk("s_last", s_last, sbq[0].last);
      end else begin
        chk("s_out_idle", s_out, 0);
        chk("s_last_idle", s_last, 0);
      end
      if (en) sipo = {s_out, sipo[3:1]};
      if (busy && en) begin
        e = sbq.pop_front();
        if (e.last) chk("sipo_word", sipo, e.word);
      end
      if (p_valid && exp_ready) begin
        for (int i = 0; i < 4; i++) begin
          e.b    = p_in[i];
          e.last = (i == 3);
          e.word = p_in;
          sbq.push_back(e);
        end
      end
    end
  end

  // Presents w and returns at posedge+1 of the accepting edge (first bit now on s_out)
  task automatic send(input logic [3:0] w);
    logic ok;
    ok      = 1'b0;
    p_in    = w;
    p_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = p_ready;
      @(posedge clk);
      #1;
    end
    p_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #2;
      done = (sbq.size() == 0) && !s_active;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    logic en_pat [6];
    en_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    rst_n   = 1'b0;
    en      = 1'b1;
    p_in    = 4'h0;
    p_valid = 1'b0;

    // Test 1: reset held across three edges
    #1;
    chk("rst_s_out", s_out, 0);
    chk("rst_s_active", s_active, 0);
    chk("rst_p_ready", p_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_s_out", s_out, 0);
      chk("rst_hold_s_active", s_active, 0);
      chk("rst_hold_s_last", s_last, 0);
      chk("rst_hold_p_ready", p_ready, 1);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 2: single word 1011
    send(4'b1011);
    chk("t2_first_bit", s_out, 1);
    wait_idle();

    // Test 3: back-to-back A then 5
    send(4'hA);
    send(4'h5);
    wait_idle();

    // Test 4: en toggled mid-word
    send(4'hC);
    foreach (en_pat[i]) begin
      en = en_pat[i];
      @(posedge clk);
      #1;
    end
    en = 1'b1;
    wait_idle();

    // Test 5: async reset mid-word, then a fresh word
    send(4'hF);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_s_out", s_out, 0);
    chk("t5_rst_s_active", s_active, 0);
    chk("t5_rst_p_ready", p_ready, 1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(4'h3);
    wait_idle();

    // Test 6: p_valid toggling while busy must not disturb the word in flight
    send(4'h9);
    for (int i = 0; i < 3; i++) begin
      p_in    = 4'h6;
      p_valid = ~i[0];
      @(posedge clk);
      #1;
    end
    p_valid = 1'b0;
    wait_idle();
    chk("final_queue_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
